// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, SubBytes FSM encoding, forward S-box table
// and the helper that maps a byte index onto its bit slice in a 128-bit state.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_BUSY = 2'd1,
        SB_DONE = 2'd2
    } sb_state_t;

    // Entry 0x00 occupies the top byte, so entry i sits at bits [2047-8*i -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte 0 is the most significant byte of the state.
    function automatic int byte_msb(input int idx);
        return AES_STATE_W - 1 - 8 * idx;
    endfunction

endpackage

// File: rtl/sub_bytes_engine_sbox.sv
// Combinational AES S-box lanes: forward table lookup, plus the inverse lookup that is
// only compiled when SUBBYTES_INV_EN is defined.
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // {~b, 3'b111} equals 2047 - 8*b, the top bit of table entry b.
    assign out_byte = SBOX_TABLE[{~in_byte, 3'b111} -: 8];

endmodule

`ifdef SUBBYTES_INV_EN
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // The S-box is a permutation, so the inverse is the unique index whose entry matches.
    always_comb begin
        out_byte = 8'h00;
        for (int i = 0; i < 256; i++) begin
            if (SBOX_TABLE[2047 - 8 * i -: 8] == in_byte) begin
                out_byte = 8'(i);
            end
        end
    end

endmodule
`endif

// File: rtl/sub_bytes_engine.sv
// Sequential AES SubBytes engine, BYTES_PER_CYCLE S-box lanes sweeping the state in place.
// Define SUBBYTES_INV_EN to add the inv port and per-lane inverse S-boxes.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data
`ifdef SUBBYTES_INV_EN
    ,
    input  logic                   inv
`endif
);

    localparam int GROUPS = AES_BYTES / BYTES_PER_CYCLE;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUPS - 1);

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
            $error("sub_bytes_engine: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    sb_state_t              fsm;
    logic [CNT_W-1:0]       cnt;
    logic [AES_STATE_W-1:0] state_reg;
    logic [AES_STATE_W-1:0] state_next;
    logic [7:0]             lane_in  [BYTES_PER_CYCLE];
    logic [7:0]             lane_out [BYTES_PER_CYCLE];
`ifdef SUBBYTES_INV_EN
    logic                   inv_q;
`endif

    always_comb begin
        for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
            lane_in[k] = state_reg[byte_msb(int'(cnt) * BYTES_PER_CYCLE + k) -: 8];
        end
    end

    // Only the current group is rewritten; every other byte passes through untouched.
    always_comb begin
        state_next = state_reg;
        for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
            state_next[byte_msb(int'(cnt) * BYTES_PER_CYCLE + k) -: 8] = lane_out[k];
        end
    end

    for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_lane
        logic [7:0] fwd;
        sbox u_sbox (.in_byte(lane_in[k]), .out_byte(fwd));
`ifdef SUBBYTES_INV_EN
        logic [7:0] rev;
        inv_sbox u_inv_sbox (.in_byte(lane_in[k]), .out_byte(rev));
        assign lane_out[k] = inv_q ? rev : fwd;
`else
        assign lane_out[k] = fwd;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= SB_IDLE;
            cnt       <= '0;
            state_reg <= '0;
`ifdef SUBBYTES_INV_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            case (fsm)
                SB_IDLE: begin
                    if (in_valid) begin
                        state_reg <= in_data;
                        cnt       <= '0;
`ifdef SUBBYTES_INV_EN
                        inv_q     <= inv;
`endif
                        fsm       <= SB_BUSY;
                    end
                end
                SB_BUSY: begin
                    state_reg <= state_next;
                    if (cnt == LAST_CNT) begin
                        fsm <= SB_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SB_DONE: begin
                    if (out_ready) begin
                        fsm <= SB_IDLE;
                    end
                end
                default: fsm <= SB_IDLE;
            endcase
        end
    end

    assign in_ready  = (fsm == SB_IDLE);
    assign out_valid = (fsm == SB_DONE);
    assign out_data  = state_reg;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: three lane widths (4, 1, 16) side by side,
// hand-computed FIPS-197 vectors, latency, backpressure and mid-operation reset.
module tb_sub_bytes_engine;

    localparam logic [127:0] V1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] E1 = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] V2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] E2 = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] V4 = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] E4 = 128'h1628c14beaaceec4f533fc1bc3938263;
    localparam logic [127:0] ALL63 = {16{8'h63}};

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic         out_ready;
    logic         v4, v1, v16;
    logic         rdy4, rdy1, rdy16;
    logic         ov4, ov1, ov16;
    logic [127:0] od4, od1, od16;
`ifdef SUBBYTES_INV_EN
    logic         inv;
`endif

    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    sub_bytes_engine #(.BYTES_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_data(in_data),
        .out_valid(ov4), .out_ready(out_ready), .out_data(od4)
`ifdef SUBBYTES_INV_EN
        , .inv(inv)
`endif
    );

    sub_bytes_engine #(.BYTES_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1)
`ifdef SUBBYTES_INV_EN
        , .inv(inv)
`endif
    );

    sub_bytes_engine #(.BYTES_PER_CYCLE(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .in_data(in_data),
        .out_valid(ov16), .out_ready(out_ready), .out_data(od16)
`ifdef SUBBYTES_INV_EN
        , .inv(inv)
`endif
    );

    task automatic check_output(input string tag, input logic [127:0] observed,
                                input logic [127:0] expected);
        assertions++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents a state to the B=4 engine for one cycle, then scrambles in_data.
    task automatic apply_stimulus(input logic [127:0] data);
        in_data = data;
        v4      = 1'b1;
        @(negedge clk);
        v4      = 1'b0;
        in_data = ~data;
    endtask

    // Cycles counted from the presentation cycle; the caller is one cycle past it.
    task automatic wait_valid4(output int cycles);
        cycles = 1;
        while (ov4 !== 1'b1 && cycles < 64) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        int c, lat1, lat16;
        logic [127:0] d1, d16;
        logic stable;

        rst = 1'b1; in_data = '0; out_ready = 1'b1;
        v4 = 1'b0; v1 = 1'b0; v16 = 1'b0;
`ifdef SUBBYTES_INV_EN
        inv = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("reset_in_ready", 128'(rdy4), 128'd1);
        check_output("reset_out_valid", 128'(ov4), 128'd0);
        check_output("reset_out_data", od4, 128'h0);
        check_output("reset_out_valid_b1", 128'(ov1), 128'd0);
        check_output("reset_out_valid_b16", 128'(ov16), 128'd0);

        // FIPS-197 style vector on B=4, in_data scrambled while busy
        apply_stimulus(V1);
        check_output("busy_in_ready", 128'(rdy4), 128'd0);
        wait_valid4(c);
        check_output("latency_b4", 128'(c), 128'd5);
        check_output("data_b4_v1", od4, E1);
        check_output("done_in_ready", 128'(rdy4), 128'd0);
        @(negedge clk);
        check_output("release_out_valid", 128'(ov4), 128'd0);
        check_output("release_in_ready", 128'(rdy4), 128'd1);

        // All-zero state through B=1 and B=16 at once
        in_data = '0; v1 = 1'b1; v16 = 1'b1;
        @(negedge clk);
        v1 = 1'b0; v16 = 1'b0; in_data = V1;
        c = 1; lat1 = 0; lat16 = 0; d1 = '0; d16 = '0;
        while ((lat1 == 0 || lat16 == 0) && c < 64) begin
            if (ov1 === 1'b1 && lat1 == 0) begin lat1 = c; d1 = od1; end
            if (ov16 === 1'b1 && lat16 == 0) begin lat16 = c; d16 = od16; end
            if (lat1 == 0 || lat16 == 0) begin
                @(negedge clk);
                c++;
            end
        end
        check_output("latency_b1", 128'(lat1), 128'd17);
        check_output("data_b1_zero", d1, ALL63);
        check_output("latency_b16", 128'(lat16), 128'd2);
        check_output("data_b16_zero", d16, ALL63);
        check_output("b4_untouched", 128'(ov4), 128'd0);

        // Backpressure: result held while in_valid offers a competing state
        out_ready = 1'b0;
        apply_stimulus(V2);
        wait_valid4(c);
        check_output("latency_b4_bp", 128'(c), 128'd5);
        v4 = 1'b1; in_data = V4;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (od4 !== E2 || ov4 !== 1'b1 || rdy4 !== 1'b0) stable = 1'b0;
        end
        check_output("backpressure_stable", 128'(stable), 128'd1);
        check_output("backpressure_data", od4, E2);
        v4 = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check_output("bp_release_valid", 128'(ov4), 128'd0);
        check_output("bp_release_ready", 128'(rdy4), 128'd1);
        @(negedge clk);
        check_output("no_stray_accept", 128'(rdy4), 128'd1);

        // Reset after two of four groups
        apply_stimulus(V1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("midreset_in_ready", 128'(rdy4), 128'd1);
        check_output("midreset_out_valid", 128'(ov4), 128'd0);
        check_output("midreset_out_data", od4, 128'h0);
        apply_stimulus(V4);
        wait_valid4(c);
        check_output("latency_after_reset", 128'(c), 128'd5);
        check_output("data_after_reset", od4, E4);
        @(negedge clk);

`ifdef SUBBYTES_INV_EN
        // Inverse substitution, with inv toggled while busy
        inv = 1'b1;
        apply_stimulus(E1);
        inv = 1'b0;
        @(negedge clk);
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        wait_valid4(c);
        check_output("latency_inv", 128'(c), 128'd5);
        check_output("data_inv", od4, V1);
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
